array_eyeriss_seq: RTL



---
 rtl/array_eyeriss_seq_pkg.sv | 14 +
 rtl/wght_sm_conv.sv | 13 +
 rtl/array_eyeriss_seq.sv | 131 +++++++++++++
 3 files changed

// File: rtl/array_eyeriss_seq_pkg.sv
// array_eyeriss_seq_pkg: sequencer state encoding and timing constants derived from array geometry.
package array_eyeriss_seq_pkg;
  typedef enum logic [3:0] {
    S_IDLE, S_WCLR, S_WLOAD, S_CLEAR, S_FETCH, S_MAC, S_DRAIN, S_OUT, S_FIN
  } seq_state_e;
  function automatic int cyc_of(int iwidth);
    return 1 << (iwidth - 1);
  endfunction
  function automatic int drain_of(int height, int width);
    return height + width;
  endfunction
  localparam int CYC = cyc_of(8);
  localparam int DRAIN = drain_of(12, 14);
endpackage

// File: rtl/wght_sm_conv.sv
// wght_sm_conv: two's-complement weight to sign/magnitude, magnitude saturated so the most negative code stays representable.
module wght_sm_conv #(
  parameter int IWIDTH = 8
) (
  input  logic [IWIDTH-1:0] w,
  output logic              sign,
  output logic [IWIDTH-2:0] mag
);
  logic [IWIDTH-1:0] a;
  assign sign = w[IWIDTH-1];
  assign a = sign ? ~w + 1'b1 : w;
  assign mag = a[IWIDTH-1] ? '1 : a[IWIDTH-2:0];
endmodule

// File: rtl/array_eyeriss_seq.sv
// array_eyeriss_seq: loads weights, streams ifm vectors and drains column results of one array_eyeriss instance.
module array_eyeriss_seq
  import array_eyeriss_seq_pkg::*;
#(
  parameter int HEIGHT = 12,
  parameter int WIDTH  = 14,
  parameter int IWIDTH = 8,
  parameter int OWIDTH = 16
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               start,
  input  logic [15:0]                        num_vec,
  input  logic [WIDTH-1:0][IWIDTH-1:0]       wght_in,
  input  logic                               ifm_valid,
  output logic                               ifm_ready,
  input  logic [HEIGHT-1:0][IWIDTH-1:0]      ifm_data,
  output logic                               res_valid,
  input  logic                               res_ready,
  output logic [WIDTH-1:0][OWIDTH-1:0]       res_data,
  output logic                               busy,
  output logic                               done,
  output logic [HEIGHT-1:0]                  en_i,
  output logic [HEIGHT-1:0]                  clr_i,
  output logic [HEIGHT-1:0]                  mac_done,
  output logic [WIDTH-1:0]                   en_w,
  output logic [WIDTH-1:0]                   clr_w,
  output logic [WIDTH-1:0]                   en_o,
  output logic [WIDTH-1:0]                   clr_o,
  output logic [HEIGHT-1:0][IWIDTH-1:0]      ifm,
  output logic [WIDTH-1:0]                   wght_sign,
  output logic [WIDTH-1:0][IWIDTH-2:0]       wght_abs,
  input  logic [WIDTH-1:0][OWIDTH-1:0]       ofm_arr
);
  localparam int DRN = drain_of(HEIGHT, WIDTH);
  localparam int DW = $clog2(DRN + 1);
  localparam logic [IWIDTH-2:0] C_LAST = '1;
  localparam logic [DW-1:0] D_LAST = DW'(DRN - 1);
  seq_state_e state, state_n;
  logic [IWIDTH-2:0] cnt, cnt_n;
  logic [DW-1:0] dcnt, dcnt_n;
  logic [15:0] vcnt, vcnt_n;
  logic [WIDTH-1:0][IWIDTH-1:0] w_q;
  logic [WIDTH-1:0] sgn;
  logic [WIDTH-1:0][IWIDTH-2:0] mag;
  logic acc, cap;
  for (genvar c = 0; c < WIDTH; c++) begin : g_conv
    wght_sm_conv #(.IWIDTH(IWIDTH)) u_conv (.w(w_q[c]), .sign(sgn[c]), .mag(mag[c]));
  end
  assign acc = ifm_valid && ifm_ready;
  assign cap = (state == S_DRAIN) && (dcnt == D_LAST);
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    dcnt_n = dcnt;
    vcnt_n = vcnt;
    case (state)
      S_IDLE: if (start) begin
        vcnt_n = num_vec;
        state_n = (num_vec == '0) ? S_FIN : S_WCLR;
      end
      S_WCLR:  state_n = S_WLOAD;
      S_WLOAD: state_n = S_CLEAR;
      S_CLEAR: state_n = S_FETCH;
      S_FETCH: if (acc) begin
        cnt_n = '0;
        state_n = S_MAC;
      end
      S_MAC: begin
        cnt_n = cnt + 1'b1;
        dcnt_n = '0;
        if (cnt == C_LAST) state_n = S_DRAIN;
      end
      S_DRAIN: begin
        dcnt_n = dcnt + 1'b1;
        if (cap) state_n = S_OUT;
      end
      S_OUT: if (res_ready) begin
        vcnt_n = vcnt - 16'(vcnt != '0);
        state_n = (vcnt_n != '0) ? S_CLEAR : S_FIN;
      end
      default: state_n = S_IDLE;
    endcase
  end
  // Outputs are registered from the next-state view so each tracks its state exactly.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      cnt <= '0;
      dcnt <= '0;
      vcnt <= '0;
      w_q <= '0;
      en_i <= '0;
      mac_done <= '0;
      clr_i <= '0;
      en_w <= '0;
      clr_w <= '0;
      en_o <= '0;
      clr_o <= '0;
      ifm_ready <= 1'b0;
      res_valid <= 1'b0;
      done <= 1'b0;
      busy <= 1'b0;
      wght_sign <= '0;
      wght_abs <= '0;
      ifm <= '0;
      res_data <= '0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      dcnt <= dcnt_n;
      vcnt <= vcnt_n;
      if (state == S_IDLE && start) w_q <= wght_in;
      en_i <= {HEIGHT{state_n == S_MAC}};
      mac_done <= {HEIGHT{state_n == S_MAC && cnt_n == C_LAST}};
      clr_i <= {HEIGHT{state_n == S_CLEAR}};
      en_w <= {WIDTH{state_n == S_WLOAD}};
      clr_w <= {WIDTH{state_n == S_WCLR}};
      en_o <= {WIDTH{state_n == S_DRAIN}};
      clr_o <= {WIDTH{state_n == S_CLEAR}};
      ifm_ready <= state_n == S_FETCH;
      res_valid <= state_n == S_OUT;
      done <= state_n == S_FIN;
      busy <= state_n != S_IDLE && state_n != S_FIN;
      wght_sign <= state_n == S_IDLE ? '0 : state_n == S_WLOAD ? sgn : wght_sign;
      wght_abs <= state_n == S_IDLE ? '0 : state_n == S_WLOAD ? mag : wght_abs;
      ifm <= state_n == S_IDLE ? '0 : acc ? ifm_data : ifm;
      res_data <= state_n == S_IDLE ? '0 : cap ? ofm_arr : res_data;
    end
  end
endmodule
